// File: rtl/ir_protocol_pkg.sv
// IR car-control protocol: FSM states, per-colour pulse lengths, colour codes.
// Shared by the IR transmitter and ir_packet_receiver.
package ir_protocol_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_BIT3,
    S_BIT2,
    S_BIT1,
    S_BIT0
  } rx_state_e;

  // Nominal lengths in carrier-period ticks.
  typedef struct packed {
    logic [8:0] start;
    logic [8:0] sel;
    logic [8:0] asrt;
    logic [8:0] deas;
    logic [8:0] gap;
  } colour_len_t;

  localparam logic [3:0] COL_BLUE     = 4'b1000;
  localparam logic [3:0] COL_YELLOW   = 4'b1001;
  localparam logic [3:0] COL_GREEN    = 4'b1010;
  localparam logic [3:0] COL_RED      = 4'b1011;
  localparam logic [3:0] COL_NOCOLOUR = 4'b1100;

  localparam colour_len_t BLUE_LEN =
    '{9'd191, 9'd47, 9'd47, 9'd22, 9'd50};
  localparam colour_len_t YELLOW_LEN =
    '{9'd191, 9'd71, 9'd47, 9'd22, 9'd50};
  localparam colour_len_t GREEN_LEN =
    '{9'd191, 9'd95, 9'd47, 9'd22, 9'd50};
  localparam colour_len_t RED_LEN =
    '{9'd191, 9'd119, 9'd47, 9'd22, 9'd50};

  function automatic colour_len_t colour_len(
    input logic [3:0] code
  );
    colour_len_t r;
    r = BLUE_LEN;
    unique case (code)
      COL_YELLOW: r = YELLOW_LEN;
      COL_GREEN:  r = GREEN_LEN;
      COL_RED:    r = RED_LEN;
      default:    r = BLUE_LEN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Synchronizes IR_IN and measures each level in prescaled ticks.
// Ports: CLK, RESET, ir_i -> rise_o, fall_o, tick_o, len_o.
module ir_pulse_timer
  import ir_protocol_pkg::*;
#(
  parameter int TICK_DIV = 2778,
  parameter int LEN_W    = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ir_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic             tick_o,
  output logic [LEN_W-1:0] len_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [PW-1:0]    cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;
  logic             edge_s;
  logic             tick;

  // The edge cycle counts as prescaler count 0, so a level stable
  // for C cycles reads back as floor(C / TICK_DIV) at its end.
  always_comb begin
    edge_s  = sync2_q ^ prev_q;
    cnt     = edge_s ? '0 : presc_q;
    tick    = (cnt == TERM);
    presc_d = tick ? '0 : cnt + 1'b1;
    len_d   = len_q;
    if (edge_s)
      len_d = '0;
    else if (tick && !(&len_q))
      len_d = len_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      presc_q <= '0;
      len_q   <= '0;
    end else begin
      sync1_q <= ir_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      presc_q <= presc_d;
      len_q   <= len_d;
    end
  end

  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;
  assign tick_o = tick;
  assign len_o  = len_q;

endmodule

// File: rtl/ir_packet_receiver.sv
// Decodes Start/Select/4-bit IR packets into a validated drive command.
// Ports: CLK, RESET, IR_IN -> COMMAND, CMD_VALID, ERROR, BUSY.
module ir_packet_receiver
  import ir_protocol_pkg::*;
#(
  parameter int TICK_DIV     = 2778,
  parameter int LEN_W        = 9,
  parameter int START_LEN    = 191,
  parameter int SEL_LEN      = 47,
  parameter int ASSERT_LEN   = 47,
  parameter int DEASSERT_LEN = 22,
  parameter int TOL          = 3,
  parameter int GAP_MAX      = 50
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  output logic [3:0] COMMAND,
  output logic       CMD_VALID,
  output logic       ERROR,
  output logic       BUSY
);

  logic             rise;
  logic             fall;
  logic             tick;
  logic [LEN_W-1:0] len;

  ir_pulse_timer #(
    .TICK_DIV (TICK_DIV),
    .LEN_W    (LEN_W)
  ) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .ir_i   (IR_IN),
    .rise_o (rise),
    .fall_o (fall),
    .tick_o (tick),
    .len_o  (len)
  );

  function automatic logic in_win(
    input logic [LEN_W-1:0] l,
    input int               n
  );
    int li;
    li = int'(l);
    return (&l) ? 1'b0 : (li >= n - TOL) && (li <= n + TOL);
  endfunction

  logic is_start;
  logic is_sel;
  logic is_one;
  logic is_zero;
  logic is_bit;
  logic timeout;

  rx_state_e  state_q;
  logic [3:0] shadow_q;
  logic [3:0] cmd_q;
  logic       vld_q;
  logic       err_q;
  logic       gap_q;

  always_comb begin
    is_start = in_win(len, START_LEN);
    is_sel   = in_win(len, SEL_LEN);
    is_one   = in_win(len, ASSERT_LEN);
    is_zero  = in_win(len, DEASSERT_LEN);
    is_bit   = is_one | is_zero;
    // Fires on the tick taking the gap from GAP_MAX to GAP_MAX+1.
    timeout  = (state_q != S_IDLE) && gap_q && tick
            && (len == LEN_W'(GAP_MAX));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cmd_q    <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      if (rise)
        gap_q <= 1'b0;
      else if (fall)
        gap_q <= 1'b1;

      if (fall) begin
        if (state_q != S_IDLE && is_start) begin
          state_q <= S_SELECT;
          err_q   <= 1'b1;
        end else begin
          unique case (state_q)
            S_IDLE: begin
              if (is_start)
                state_q <= S_SELECT;
            end
            S_SELECT: begin
              state_q <= is_sel ? S_BIT3 : S_IDLE;
              err_q   <= !is_sel;
            end
            S_BIT3: begin
              shadow_q[3] <= is_one;
              state_q     <= is_bit ? S_BIT2 : S_IDLE;
              err_q       <= !is_bit;
            end
            S_BIT2: begin
              shadow_q[2] <= is_one;
              state_q     <= is_bit ? S_BIT1 : S_IDLE;
              err_q       <= !is_bit;
            end
            S_BIT1: begin
              shadow_q[1] <= is_one;
              state_q     <= is_bit ? S_BIT0 : S_IDLE;
              err_q       <= !is_bit;
            end
            S_BIT0: begin
              shadow_q[0] <= is_one;
              state_q     <= S_IDLE;
              if (is_bit) begin
                cmd_q <= {shadow_q[3:1], is_one};
                vld_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end else if (timeout) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
      end
    end
  end

  assign COMMAND   = cmd_q;
  assign CMD_VALID = vld_q;
  assign ERROR     = err_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_packet_receiver.sv
// Directed bench for ir_packet_receiver with an event scoreboard.
// TICK_DIV=10, other parameters default.
module tb_ir_packet_receiver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       IR_IN;
  logic [3:0] COMMAND;
  logic       CMD_VALID;
  logic       ERROR;
  logic       BUSY;

  ir_packet_receiver #(
    .TICK_DIV (10)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IR_IN     (IR_IN),
    .COMMAND   (COMMAND),
    .CMD_VALID (CMD_VALID),
    .ERROR     (ERROR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // kind 1 = CMD_VALID, kind 2 = ERROR
  typedef struct {
    int         kind;
    logic [3:0] cmd;
    int         due;
  } ev_t;

  ev_t sb[$];
  ev_t ev;

  localparam int ST = 1910;
  localparam int SL = 470;
  localparam int B1 = 470;
  localparam int B0 = 220;
  localparam int GP = 250;

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n,
                       input int kind = 0,
                       input logic [3:0] cmd = 4'd0,
                       input int lat = 3);
    @(posedge CLK);
    #1;
    IR_IN = v;
    if (kind != 0)
      sb.push_back('{kind, cmd, cyc + lat});
    repeat (n - 1) @(posedge CLK);
  endtask

  task automatic burst(input int h, input int g,
                       input int kind = 0,
                       input logic [3:0] cmd = 4'd0,
                       input int lat = 3);
    drive(1'b1, h);
    drive(1'b0, g, kind, cmd, lat);
  endtask

  task automatic head(input int sel = SL);
    burst(ST, GP);
    burst(sel, GP);
  endtask

  task automatic bits(input logic [3:0] b, input int kind,
                      input logic [3:0] cmd);
    for (int i = 3; i >= 0; i--)
      burst(b[i] ? B1 : B0, GP, (i == 0) ? kind : 0, cmd);
  endtask

  logic [3:0] prev_cmd = 4'd0;
  logic       rst_prev = 1'b1;

  always @(negedge CLK) begin
    if (CMD_VALID || ERROR) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", int'({CMD_VALID, ERROR}), 0);
      end else begin
        ev = sb.pop_front();
        chk("strobe_kind", int'({CMD_VALID, ERROR}),
            (ev.kind == 1) ? 2 : 1);
        chk("strobe_cycle", cyc, ev.due);
        if (ev.kind == 1)
          chk("command", int'(COMMAND), int'(ev.cmd));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      ev = sb.pop_front();
      chk("missing_strobe", cyc, ev.due);
    end
    if (!CMD_VALID && !rst_prev && COMMAND !== prev_cmd)
      chk("command_hold", int'(COMMAND), int'(prev_cmd));
    prev_cmd = COMMAND;
    rst_prev = RESET;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    IR_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_command", int'(COMMAND), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_valid", int'(CMD_VALID), 0);
    chk("rst_error", int'(ERROR), 0);

    // Valid packet 1001
    burst(ST, GP);
    @(negedge CLK);
    chk("busy_after_start", int'(BUSY), 1);
    burst(SL, GP);
    bits(4'b1001, 1, 4'b1001);
    @(negedge CLK);
    chk("busy_after_pkt", int'(BUSY), 0);
    chk("cmd_1001", int'(COMMAND), 4'b1001);

    // Select tolerance edges
    head(500);
    bits(4'b0110, 1, 4'b0110);
    head(440);
    bits(4'b1010, 1, 4'b1010);
    burst(ST, GP);
    burst(510, 600, 2);
    @(negedge CLK);
    chk("sel51_cmd_kept", int'(COMMAND), 4'b1010);
    chk("sel51_idle", int'(BUSY), 0);

    // Gap timeout after select
    burst(ST, GP);
    burst(SL, 600, 2, 4'd0, 512);
    @(negedge CLK);
    chk("timeout_idle", int'(BUSY), 0);

    // Bad bit at BIT2, then a clean packet
    head();
    burst(B1, GP);
    burst(330, 600, 2);
    head();
    bits(4'b0101, 1, 4'b0101);

    // Start resync during BIT1
    head();
    burst(B1, GP);
    burst(B1, GP);
    burst(ST, GP, 2);
    @(negedge CLK);
    chk("resync_busy", int'(BUSY), 1);
    burst(SL, GP);
    bits(4'b0000, 1, 4'b0000);

    // Reset in BIT2 discards the packet
    head();
    bits(4'b1111, 1, 4'b1111);
    head();
    burst(B1, 100);
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_command", int'(COMMAND), 0);
    chk("midrst_busy", int'(BUSY), 0);
    drive(1'b0, 150);
    burst(B0, GP);
    burst(B1, GP);
    burst(B1, 600);
    @(negedge CLK);
    chk("postrst_command", int'(COMMAND), 0);
    chk("postrst_busy", int'(BUSY), 0);

    repeat (20) @(posedge CLK);
    chk("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
